// File: rtl/ext_stage_pkg.sv
// Shared constants for the immediate-extension stage: mode encodings and default geometry.
package ext_stage_pkg;

    localparam int EXT_OP_W = 2;

    typedef enum logic [EXT_OP_W-1:0] {
        EXT_ZERO = 2'd0,
        EXT_SIGN = 2'd1,
        EXT_LUI  = 2'd2,
        EXT_SHL2 = 2'd3
    } ext_op_e;

    localparam int EXT_IN_W_DEF   = 16;
    localparam int EXT_OUT_W_DEF  = 32;
    localparam int EXT_STAGES_MAX = 3;

endpackage

// File: rtl/ext_stage_if.sv
// Decode-side handshake into the extender and the staged result handed to the D/E register.
interface ext_stage_if
    import ext_stage_pkg::*;
#(
    parameter int IN_W  = EXT_IN_W_DEF,
    parameter int OUT_W = EXT_OUT_W_DEF
) ();

    logic                in_valid;
    logic [IN_W-1:0]     in_imm;
    logic [EXT_OP_W-1:0] in_op;
    logic                stall;
    logic                flush;
    logic                out_valid;
    logic [OUT_W-1:0]    out_imm;
    logic [EXT_OP_W-1:0] out_op;

    modport master (
        output in_valid, in_imm, in_op, stall, flush,
        input  out_valid, out_imm, out_op
    );

    modport slave (
        input  in_valid, in_imm, in_op, stall, flush,
        output out_valid, out_imm, out_op
    );

endinterface

// File: rtl/ext_stage_core.sv
// Combinational immediate extender: zero, sign, upper-immediate and sign-extend-shift-by-2.
module ext_core
    import ext_stage_pkg::*;
#(
    parameter int IN_W  = EXT_IN_W_DEF,
    parameter int OUT_W = EXT_OUT_W_DEF
) (
    input  logic [IN_W-1:0]     imm_i,
    input  logic [EXT_OP_W-1:0] op_i,
    output logic [OUT_W-1:0]    ext_o
);

    // SHL2 drops the top two sign bits, so it needs at least two bits of headroom.
    if (OUT_W < IN_W + 2) begin : g_bad_width
        $error("ext_core: OUT_W must be at least IN_W+2");
    end

    logic [OUT_W-1:0] sext;

    assign sext = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

    always_comb begin
        ext_o = '0;
        case (op_i)
            EXT_ZERO: ext_o = {{(OUT_W-IN_W){1'b0}}, imm_i};
            EXT_SIGN: ext_o = sext;
            EXT_LUI:  ext_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
            EXT_SHL2: ext_o = {sext[OUT_W-3:0], 2'b00};
            default:  ext_o = '0;
        endcase
    end

endmodule

// File: rtl/ext_stage.sv
// Immediate extender followed by 0..3 stall/flush-aware register slices so the extended
// value stays aligned with the instruction slot it belongs to.
module ext_stage
    import ext_stage_pkg::*;
#(
    parameter int IN_W   = EXT_IN_W_DEF,
    parameter int OUT_W  = EXT_OUT_W_DEF,
    parameter int STAGES = 1
) (
    input  logic        clk,
    input  logic        reset,
    ext_stage_if.slave  ext
);

    if (STAGES < 0 || STAGES > EXT_STAGES_MAX) begin : g_bad_stages
        $error("ext_stage: STAGES must be in 0..3");
    end

    logic [OUT_W-1:0] core_imm;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm_i (ext.in_imm),
        .op_i  (ext.in_op),
        .ext_o (core_imm)
    );

    // Index 0 is the unregistered core result; index k+1 is the output of slice k.
    logic [STAGES:0]                    chain_vld;
    logic [STAGES:0][OUT_W-1:0]         chain_imm;
    logic [STAGES:0][EXT_OP_W-1:0]      chain_op;

    assign chain_vld[0] = ext.in_valid;
    assign chain_imm[0] = core_imm;
    assign chain_op[0]  = ext.in_op;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic                vld_q, vld_d;
        logic [OUT_W-1:0]    imm_q, imm_d;
        logic [EXT_OP_W-1:0] op_q,  op_d;

        // Invalid slots carry zero data so consumers never see a stale immediate.
        always_comb begin
            vld_d = vld_q;
            imm_d = imm_q;
            op_d  = op_q;
            if (ext.flush) begin
                vld_d = 1'b0;
                imm_d = '0;
                op_d  = '0;
            end else if (!ext.stall) begin
                vld_d = chain_vld[k];
                imm_d = chain_vld[k] ? chain_imm[k] : '0;
                op_d  = chain_vld[k] ? chain_op[k]  : '0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= 1'b0;
                imm_q <= '0;
                op_q  <= '0;
            end else begin
                vld_q <= vld_d;
                imm_q <= imm_d;
                op_q  <= op_d;
            end
        end

        assign chain_vld[k+1] = vld_q;
        assign chain_imm[k+1] = imm_q;
        assign chain_op[k+1]  = op_q;
    end

    // With no slices the control inputs are intentionally ignored.
    if (STAGES == 0) begin : g_comb_only
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, reset, ext.stall, ext.flush};
    end

    assign ext.out_valid = chain_vld[STAGES];
    assign ext.out_imm   = chain_imm[STAGES];
    assign ext.out_op    = chain_op[STAGES];

endmodule

// File: tb/tb_ext_stage.sv
// Scoreboard bench: four ext_stage instances (STAGES 0..3) share one directed stimulus stream.
module tb_ext_stage;
    import ext_stage_pkg::*;

    typedef struct packed {
        logic [31:0] imm;
        logic [1:0]  op;
        int          issue;
        int          stall_at;
    } exp_t;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_imm   = '0;
    logic [1:0]  in_op    = '0;
    logic        stall    = 1'b0;
    logic        flush    = 1'b0;

    logic        ov [4];
    logic [31:0] oi [4];
    logic [1:0]  oo [4];

    exp_t        sb [4][$];
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          stall_cnt = 0;
    bit          rst_last  = 1'b0;
    bit          hold_last = 1'b0;
    logic        last_v [4];
    logic [31:0] last_i [4];
    logic [1:0]  last_o [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ext_stage_if #(.IN_W(16), .OUT_W(32)) ifs ();

        assign ifs.in_valid = in_valid;
        assign ifs.in_imm   = in_imm;
        assign ifs.in_op    = in_op;
        assign ifs.stall    = stall;
        assign ifs.flush    = flush;

        ext_stage #(.IN_W(16), .OUT_W(32), .STAGES(g)) dut (
            .clk   (clk),
            .reset (reset),
            .ext   (ifs)
        );

        assign ov[g] = ifs.out_valid;
        assign oi[g] = ifs.out_imm;
        assign oo[g] = ifs.out_op;
    end

    task automatic chk(input bit ok, input string name, input int s,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s stages=%0d cyc=%0d actual=%h required=%h", name, s, cyc, act, req);
        end
    endtask

    // Edge bookkeeping: cycle stamp, hold count, and pipeline kills on reset/flush.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rst_last  <= reset;
        hold_last <= stall && !flush && !reset;
        if (stall && !flush && !reset) stall_cnt <= stall_cnt + 1;
        if (reset || flush) begin
            for (int s = 1; s < 4; s++) sb[s].delete();
        end
    end

    initial begin
        for (int s = 0; s < 4; s++) begin
            last_v[s] = 1'b0;
            last_i[s] = '0;
            last_o[s] = '0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        int   el;
        for (int s = 0; s < 4; s++) begin
            if (s > 0 && rst_last) begin
                chk({ov[s], oi[s], oo[s]} == 35'd0, "reset_clear", s, {ov[s], oi[s], oo[s]}, 64'd0);
                last_v[s] <= 1'b0;
                last_i[s] <= '0;
                last_o[s] <= '0;
            end else if (s > 0 && hold_last) begin
                if (last_v[s])
                    chk({ov[s], oi[s], oo[s]} == {1'b1, last_i[s], last_o[s]}, "stall_hold", s,
                        {ov[s], oi[s], oo[s]}, {1'b1, last_i[s], last_o[s]});
                else
                    chk({ov[s], oi[s]} == 33'd0, "stall_hold_empty", s, {ov[s], oi[s]}, 64'd0);
            end else if (ov[s]) begin
                chk(sb[s].size() != 0, "unexpected_valid", s, oi[s], 64'd0);
                if (sb[s].size() != 0) begin
                    e  = sb[s].pop_front();
                    el = (cyc - e.issue) - (stall_cnt - e.stall_at);
                    chk({oi[s], oo[s]} == {e.imm, e.op}, "data", s, {oi[s], oo[s]}, {e.imm, e.op});
                    chk(el == s, "latency", s, el, s);
                    last_v[s] <= 1'b1;
                    last_i[s] <= e.imm;
                    last_o[s] <= e.op;
                end
            end else begin
                if (s > 0) chk(oi[s] == 32'd0, "bubble_zero", s, oi[s], 64'd0);
                last_v[s] <= 1'b0;
                last_i[s] <= '0;
                last_o[s] <= '0;
                if (sb[s].size() != 0) begin
                    e  = sb[s][0];
                    el = (cyc - e.issue) - (stall_cnt - e.stall_at);
                    if (el >= s) begin
                        checks++;
                        failures++;
                        $display("FAIL missing_beat stages=%0d cyc=%0d actual=invalid required=%h", s, cyc, e.imm);
                        void'(sb[s].pop_front());
                    end
                end
            end
        end
    end

    // One cycle of stimulus; expected results are queued for every instance that will emit them.
    task automatic beat(input bit v, input logic [15:0] imm, input logic [1:0] op,
                        input logic [31:0] exp_imm, input bit st, input bit fl, input bit rs);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        in_imm   = imm;
        in_op    = op;
        stall    = st;
        flush    = fl;
        reset    = rs;
        e.imm      = exp_imm;
        e.op       = op;
        e.issue    = cyc;
        e.stall_at = stall_cnt;
        if (v) begin
            for (int s = 0; s < 4; s++) begin
                if (s == 0 || (!st && !fl && !rs)) sb[s].push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 16'h0000, EXT_ZERO, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) beat(1'b0, 16'h0000, EXT_ZERO, 32'h0, 1'b0, 1'b0, 1'b1);

        // Extension modes, back to back
        beat(1'b1, 16'h8001, EXT_ZERO, 32'h0000_8001, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 16'h8001, EXT_SIGN, 32'hFFFF_8001, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 16'h1234, EXT_LUI,  32'h1234_0000, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 16'hFFFF, EXT_SHL2, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 16'h7FFF, EXT_SHL2, 32'h0001_FFFC, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Latency sweep stream
        beat(1'b1, 16'h0001, EXT_SIGN, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 16'h0002, EXT_SIGN, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 16'h0003, EXT_SIGN, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Stall for three cycles with B sitting in the first slice
        beat(1'b1, 16'h0010, EXT_SIGN, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 16'h0020, EXT_SIGN, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
        repeat (3) beat(1'b0, 16'h0000, EXT_ZERO, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(5);

        // Flush together with stall, then a fresh beat
        beat(1'b1, 16'h0040, EXT_ZERO, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 16'h0041, EXT_ZERO, 32'h0000_0041, 1'b0, 1'b0, 1'b0);
        beat(1'b0, 16'h0000, EXT_ZERO, 32'h0,         1'b1, 1'b1, 1'b0);
        beat(1'b1, 16'h0005, EXT_ZERO, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Reset while three beats are in flight
        beat(1'b1, 16'h0100, EXT_SIGN, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 16'h0101, EXT_SIGN, 32'h0000_0101, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 16'h0102, EXT_SIGN, 32'h0000_0102, 1'b0, 1'b0, 1'b1);
        beat(1'b1, 16'h0200, EXT_ZERO, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Alternating bubbles
        for (int i = 0; i < 6; i++) begin
            beat(i % 2 == 0, 16'hABCD, EXT_SIGN, 32'hFFFF_ABCD, 1'b0, 1'b0, 1'b0);
        end
        idle(6);

        @(negedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            chk(sb[s].size() == 0, "drained", s, sb[s].size(), 64'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_stage.md
Name: ext_stage

Overview:
- Parametrised immediate-extension unit with built-in pipeline staging.
- Successor to the single-mode combinational decode-stage extender.
- Supports four extension modes and a configurable number of register stages (0-3) with stall/flush control, so extended immediates stay aligned with the pipeline controller's stall and flush decisions.
- Sits between the decode logic and the D/E pipeline register; downstream consumers are the ALU operand mux and the branch-target adder.

Parameters:
- IN_W, 16, immediate input width in bits.
- OUT_W, 32, extended output width in bits. Must satisfy OUT_W >= IN_W+2; a violation is an elaboration error.
- STAGES, 1, number of register stages, 0..3. With 0 the block is purely combinational.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input slot holds a live instruction.
- in_imm  in  IN_W  raw immediate field.
- in_op  in  2  extension mode; encodings in the shared constants header.
- stall  in  1  hold every stage register.
- flush  in  1  invalidate every stage.
- out_valid  out  1  output slot holds a live instruction.
- out_imm  out  OUT_W  extended immediate.
- out_op  out  2  mode that produced out_imm, delayed with the data for debug/trace.

Behaviour:
- Extension modes (combinational core):
  - EXT_ZERO=0: {zeros, imm}.
  - EXT_SIGN=1: {OUT_W-IN_W copies of imm[IN_W-1], imm}.
  - EXT_LUI=2: {imm, OUT_W-IN_W zeros}.
  - EXT_SHL2=3: sign-extend, then shift left by 2 within OUT_W; the low 2 bits are 0.
- Latency: exactly STAGES cycles from input to output when stall is low.
- STAGES=0: outputs follow the inputs combinationally; stall, flush and reset have no effect on outputs.
- Stage registers, each holding {valid, imm, op}:
  - Stage 0 captures the core result and in_valid.
  - Stage k captures stage k-1.
  - Outputs come from the last stage.
- Priority at each rising edge: reset > flush > stall > advance.
  - reset=1: every valid, imm and op register goes to 0, so out_valid=0, out_imm=0, out_op=0 on the next cycle.
  - flush=1: every valid bit is cleared, including the stage being loaded this edge. Data registers may load but are don't-care while invalid. flush with stall set: flush wins.
  - stall=1, flush=0: all registers hold, and in_* is ignored that cycle. The upstream stage must hold its inputs.
  - Otherwise: the pipeline advances one stage.
- Bubbles: in_valid=0 still advances; an invalid slot propagates with its data zeroed.
- Reset mid-operation: all in-flight valids are lost. The first cycle after reset deasserts accepts new input.
- No combinational path from stall/flush to outputs when STAGES>=1.
- out_imm is 0 whenever out_valid=0 (STAGES>=1). Verification checks this.

Decomposition:
- Shared constants header gains:
  - EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_SHL2 (2-bit encodings).
  - EXT_OP_W = 2.
- One sub-module, ext_core: purely combinational, parameters IN_W and OUT_W, maps (imm, op) to the extended value.
- ext_stage instantiates ext_core and a generate loop of STAGES register slices.

Test Plan:
- Modes, STAGES=1, one beat each: in_imm=16'h8001 with op ZERO -> out_imm 32'h00008001, and with op SIGN -> 32'hFFFF8001, each one cycle later with out_valid=1. in_imm=16'h1234 with op LUI -> 32'h12340000. in_imm=16'hFFFF with op SHL2 -> 32'hFFFFFFFC. in_imm=16'h7FFF with op SHL2 -> 32'h0001FFFC.
- Latency sweep, STAGES=0..3: stream 0x0001, 0x0002, 0x0003 with SIGN -> each value appears exactly STAGES cycles later, in order, with no gaps. With STAGES=0 the output is same-cycle.
- Stall, STAGES=2: stream A=0x0010, B=0x0020, assert stall for 3 cycles while B is in stage 0 -> outputs frozen at the pre-stall values for 3 cycles; after release the order is A, B with no duplication or loss.
- Flush with stall, STAGES=2: two valid beats in flight, assert flush and stall together -> out_valid=0 on the next two cycles and out_imm=0. A new beat 0x0005/ZERO issued the cycle after flush emerges 2 cycles later.
- Reset mid-stream, STAGES=3: three beats in flight, reset high for one cycle -> out_valid=0, out_imm=0, out_op=0 next cycle and until new input propagates. Beats issued before reset never appear.
- Bubbles: alternate in_valid 1/0 with 0xABCD/SIGN -> out_valid toggles 1/0 delayed by STAGES; invalid slots show out_imm=0 and valid slots show 32'hFFFFABCD.
